// File: rtl/rvfi_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_imem_responder
// Description : Instruction-fetch responder for formal/simulation harnesses.
//               The halfword at imem_addr always reads back imem_data; all
//               other halfwords come from fill_data. Up to DEPTH requests are
//               buffered and answered in order after a minimum LATENCY.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_imem_responder #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic [31:0]     fill_data,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic            rsp_err
);

  // DEPTH is a power of two, so a log2-wide pointer wraps modulo DEPTH for free.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  // LATENCY is at most 15, so four bits hold any age value.
  localparam int unsigned AGE_W = 4;

  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
  localparam logic [AGE_W-1:0] C_LATENCY  = AGE_W'(LATENCY);
  localparam logic [AGE_W-1:0] C_AGE_ZERO = '0;

  // Per-entry storage: response word, misalignment flag, remaining wait cycles.
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [AGE_W-1:0] age_q  [DEPTH];

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic            w_push;
  logic            w_pop;
  logic            w_head_ready;
  logic            w_misaligned;
  logic            w_lo_hit;
  logic            w_hi_hit;
  logic [XLEN-1:0] w_addr_hi;
  logic [15:0]     w_lo;
  logic [15:0]     w_hi;
  logic [31:0]     w_wdata;

  // Ready depends only on occupancy: a full buffer refuses a push even if the
  // head is being popped in the same cycle.
  assign req_ready = (count_q != C_DEPTH);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready;

  // Response word is assembled at accept time from the inputs seen that cycle,
  // so later changes on imem_addr/imem_data never disturb stored entries.
  // The upper halfword address is computed in XLEN bits and wraps at the top.
  assign w_addr_hi    = req_addr + XLEN'(2);
  assign w_lo_hit     = (req_addr == imem_addr);
  assign w_hi_hit     = (w_addr_hi == imem_addr);
  assign w_lo         = w_lo_hit ? imem_data : fill_data[15:0];
  assign w_hi         = w_hi_hit ? imem_data : fill_data[31:16];
  assign w_misaligned = req_addr[0];
  assign w_wdata      = w_misaligned ? 32'd0 : {w_hi, w_lo};

  // Head is presentable once it exists and has finished its wait; outputs are
  // forced to zero otherwise so nothing stale is ever visible.
  assign w_head_ready = (count_q != C_CNT_ZERO) && (age_q[rptr_q] == C_AGE_ZERO);
  assign rsp_valid    = w_head_ready;
  assign rsp_data     = w_head_ready ? data_q[rptr_q] : 32'd0;
  assign rsp_err      = w_head_ready && err_q[rptr_q];

  // Pointer and occupancy next-state from the push/pop handshakes.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (w_push) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards every pending entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage: write on push, and age every slot toward zero each cycle
  // so entries queued behind the head mature in parallel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        age_q[i]  <= '0;
      end
      err_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (wptr_q == PTR_W'(i))) begin
          data_q[i] <= w_wdata;
          err_q[i]  <= w_misaligned;
          age_q[i]  <= C_LATENCY;
        end else if (age_q[i] != C_AGE_ZERO) begin
          age_q[i] <= age_q[i] - AGE_W'(1);
        end
      end
    end
  end

`ifdef FORMAL
  // Occupancy never exceeds the buffer size; errored responses carry no data.
  always_comb begin
    if (!reset) begin
      a_count_bound : assert (count_q <= C_DEPTH);
      a_err_zero    : assert (!(rsp_valid && rsp_err && (rsp_data != 32'd0)));
    end
  end

  // A presented response holds steady until it is taken.
  property p_rsp_stable;
    @(posedge clock) disable iff (reset)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_err));
  endproperty
  a_rsp_stable : assert property (p_rsp_stable);
`endif

endmodule
`default_nettype wire
